alu_issue_ctrl: RTL and testbench

- Single-entry issue controller for the EX stage. It sits between the ID/EX pipeline latch and the aluControl/ALU pair.
- Accepts one operation (functionCode, ALUop) per valid/ready handshake and drives the registered ALU control inputs.
- Sequences single-cycle and iterative (multi-cycle) operations, then presents the result slot downstream with a valid/ready handshake.
- Provides stall (in_ready low) and flush support to the pipeline.

---
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-entry EX-stage issue controller for the aluControl/ALU pair
module alu_issue_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_func,
   input  logic [1:0]       in_aluop,
   input  logic             flush,
   output logic [3:0]       alu_func,
   output logic [1:0]       alu_op,
   output logic             alu_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Counter holds the number of ITER cycles still to run after the current one,
   // so loading MC_CYCLES-1 keeps the ALU busy for MC_CYCLES cycles.
   localparam logic [3:0] LP_MC_LOAD = 4'(MC_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_next;
   logic [3:0]       r_alu_func;
   logic [1:0]       r_alu_op;
   logic [CNT_W-1:0] r_retired;
   logic             w_accept;
   logic             w_retire;

   // Ready depends only on state and downstream ready, never on in_valid.
   assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready & ~flush;
   assign w_retire  = (r_state == S_DONE) & out_ready & ~flush;

   assign alu_func  = r_alu_func;
   assign alu_op    = r_alu_op;
   assign alu_en    = (r_state == S_EXEC) | (r_state == S_ITER);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign retired   = r_retired;

   // Next-state and iteration counter; flush overrides everything.
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      if (flush) begin
         w_next     = S_IDLE;
         w_cnt_next = 4'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  if (in_aluop == 2'b11) begin
                     w_next     = S_ITER;
                     w_cnt_next = LP_MC_LOAD;
                  end else begin
                     w_next     = S_EXEC;
                  end
               end else if (r_state == S_DONE && out_ready) begin
                  w_next = S_IDLE;
               end
            end
            S_EXEC: begin
               w_next = S_DONE;
            end
            S_ITER: begin
               if (r_cnt == 4'd0) begin
                  w_next = S_DONE;
               end else begin
                  w_cnt_next = r_cnt - 4'd1;
               end
            end
            default: begin
               w_next     = S_IDLE;
               w_cnt_next = 4'd0;
            end
         endcase
      end
   end

   // State and iteration counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // ALU control latches only on accept and holds through ITER, DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_func <= 4'b0000;
         r_alu_op   <= 2'b00;
      end else if (w_accept) begin
         r_alu_func <= in_func;
         r_alu_op   <= in_aluop;
      end
   end

   // Retired-operation counter, wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= '0;
      end else if (w_retire) begin
         r_retired <= r_retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_func;
   logic [1:0] in_aluop;
   logic       flush;
   logic [3:0] alu_func;
   logic [1:0] alu_op;
   logic       alu_en;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic [7:0] retired;

   int n_cmp = 0;
   int n_err = 0;
   int exp_ret = 0;
   logic [5:0] sb_q[$];

   alu_issue_ctrl #(.MC_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_func(in_func), .in_aluop(in_aluop), .flush(flush),
      .alu_func(alu_func), .alu_op(alu_op), .alu_en(alu_en),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] f, input logic [1:0] op, input bit expect_ret);
      in_func  = f;
      in_aluop = op;
      in_valid = 1'b1;
      if (expect_ret) sb_q.push_back({f, op});
   endtask

   // Scoreboard: every completed handshake pops the op it should be presenting.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !flush) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_out", 32'd1, 32'd0);
         end else begin
            logic [5:0] e;
            e = sb_q.pop_front();
            check("sb_func", {28'd0, alu_func}, {28'd0, e[5:2]});
            check("sb_op", {30'd0, alu_op}, {30'd0, e[1:0]});
         end
         check("sb_retired", {24'd0, retired}, exp_ret & 32'hFF);
         exp_ret++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_func = 4'd0; in_aluop = 2'd0;
      flush = 1'b0; out_ready = 1'b0;
      #3;
      check("rst_func", {28'd0, alu_func}, 32'd0);
      check("rst_op", {30'd0, alu_op}, 32'd0);
      check("rst_en", {31'd0, alu_en}, 32'd0);
      check("rst_ov", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ret", {24'd0, retired}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single-cycle op
      out_ready = 1'b1;
      issue(4'b0010, 2'b00, 1);
      check("s_inrdy", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("s_func", {28'd0, alu_func}, 32'h2);
      check("s_op", {30'd0, alu_op}, 32'h0);
      check("s_en1", {31'd0, alu_en}, 32'd1);
      check("s_ov1", {31'd0, out_valid}, 32'd0);
      tick();
      check("s_en2", {31'd0, alu_en}, 32'd0);
      check("s_ov2", {31'd0, out_valid}, 32'd1);
      tick();
      check("s_ov3", {31'd0, out_valid}, 32'd0);
      check("s_busy", {31'd0, busy}, 32'd0);
      check("s_ret", {24'd0, retired}, 32'd1);

      // Multi-cycle op: ALU busy for four cycles, result at the fifth edge
      issue(4'b1111, 2'b11, 1);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("m_en", {31'd0, alu_en}, 32'd1);
         check("m_inrdy", {31'd0, in_ready}, 32'd0);
         check("m_ov", {31'd0, out_valid}, 32'd0);
         check("m_func", {28'd0, alu_func}, 32'hF);
         check("m_op", {30'd0, alu_op}, 32'h3);
         tick();
      end
      check("m_ov_done", {31'd0, out_valid}, 32'd1);
      check("m_en_done", {31'd0, alu_en}, 32'd0);
      tick();
      check("m_ret", {24'd0, retired}, 32'd2);

      // Backpressure in DONE
      out_ready = 1'b0;
      issue(4'b1010, 2'b10, 1);
      tick();
      in_valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("bp_ov", {31'd0, out_valid}, 32'd1);
         check("bp_func", {28'd0, alu_func}, 32'hA);
         check("bp_inrdy", {31'd0, in_ready}, 32'd0);
         check("bp_ret", {24'd0, retired}, 32'd2);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_inrdy_rel", {31'd0, in_ready}, 32'd1);
      tick();
      check("bp_ret_done", {24'd0, retired}, 32'd3);
      check("bp_idle", {31'd0, busy}, 32'd0);

      // Back-to-back accept from DONE
      issue(4'b0011, 2'b01, 1);
      tick();
      in_valid = 1'b0;
      tick();
      issue(4'b0100, 2'b00, 1);
      check("bb_inrdy", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("bb_func", {28'd0, alu_func}, 32'h4);
      check("bb_busy", {31'd0, busy}, 32'd1);
      check("bb_en", {31'd0, alu_en}, 32'd1);
      check("bb_ret", {24'd0, retired}, 32'd4);
      tick(); tick();
      check("bb_ret2", {24'd0, retired}, 32'd5);

      // Flush on the second ITER cycle, with a competing op
      issue(4'b1111, 2'b11, 0);
      tick();
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      issue(4'b0001, 2'b00, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_busy", {31'd0, busy}, 32'd0);
      check("fl_ov", {31'd0, out_valid}, 32'd0);
      check("fl_func", {28'd0, alu_func}, 32'hF);
      check("fl_op", {30'd0, alu_op}, 32'h3);
      tick();
      check("fl_ov2", {31'd0, out_valid}, 32'd0);
      check("fl_ret", {24'd0, retired}, 32'd5);

      // Flush in DONE with out_ready high
      issue(4'b0110, 2'b00, 0);
      tick();
      in_valid = 1'b0;
      tick();
      check("fd_ov", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fd_ov2", {31'd0, out_valid}, 32'd0);
      check("fd_ret", {24'd0, retired}, 32'd5);

      // Asynchronous reset mid-ITER
      issue(4'b1100, 2'b11, 0);
      tick();
      in_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_func", {28'd0, alu_func}, 32'd0);
      check("ar_op", {30'd0, alu_op}, 32'd0);
      check("ar_en", {31'd0, alu_en}, 32'd0);
      check("ar_ov", {31'd0, out_valid}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_ret", {24'd0, retired}, 32'd0);
      exp_ret = 0;
      tick();
      rst_n = 1'b1;
      tick();

      // Wrap: 256 retirements return the counter to zero
      for (int i = 0; i < 256; i++) begin
         issue(4'(i), 2'(i % 3), 1);
         tick();
         in_valid = 1'b0;
         tick();
      end
      tick();
      check("wrap_ret", {24'd0, retired}, 32'd0);
      check("wrap_cnt", exp_ret, 32'd256);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
